bg_fetch: RTL and testbench
===========================

// Module: bg_fetch
// PURPOSE
//  Background tile fetch sequencer and pixel shifter of the 2C02 PPU; sits directly upstream of
//  the PPU memory map. Drives a 14-bit read address into it and consumes its read data, which
//  is registered with 1-cycle latency. Performs the 8-dot NT/AT/PT-lo/PT-hi fetch cycle and
//  emits one 4-bit background palette index per dot to the pixel mux.
// PARAMETERS
//  ADDR_W   14       PPU address width; must match the memory map
//  NT_BASE  14'h2000 nametable base address
//  AT_OFF   10'h3C0  attribute table offset within a nametable
// PORTS
//  clk         in   1   PPU dot clock
//  rst         in   1   synchronous, active-high reset
//  fetch_en    in   1   fetch window strobe (dots 1-256, 321-336), from the timing block
//  shift_en    in   1   advance shift registers this dot
//  v           in   15  loopy v: fine_y[14:12], nt[11:10], coarse_y[9:5], coarse_x[4:0]
//  fine_x      in   3   fine X scroll
//  pt_sel      in   1   background pattern table select (PPUCTRL bit 4)
//  dot_x       in   8   screen X of the pixel being output (left-clip use only)
//  show_left   in   1   PPUMASK bit 1 (left-clip use only)
//  addr        out  14  read address to the memory map
//  rw          out  1   tied to 1 (read); this block never writes
//  data_i      in   8   read data from the memory map, valid 1 cycle after addr
//  inc_hori    out  1   1-cycle pulse: request coarse-X increment of v
//  pixel       out  4   {attr[1:0], pat_hi, pat_lo}; 0 = transparent
// BEHAVIOUR
//  - Reset: phase=0, addr=0, rw=1, inc_hori=0, pixel=0, all latches and shifters=0.
//  - phase[2:0] counts 0..7 while fetch_en=1, then wraps 7->0. fetch_en=0 forces phase to 0
//    next cycle. A partial group is discarded: no reload, no inc_hori.
//  - addr is registered and driven during each phase:
//      ph0-1  NT: NT_BASE | v[11:0]
//      ph2-3  AT: NT_BASE | v[11:10]<<10 | AT_OFF | v[9:7]<<3 | v[4:2]
//             quadrant q={v[6],v[1]} is captured at ph2
//      ph4-5  PT lo: {1'b0, pt_sel, nt_byte, 1'b0, v[14:12]}
//      ph6-7  PT hi: same as PT lo with bit 3 = 1
//  - Read data latches from data_i at the end of ph1 (nt_byte), ph3 (at_bits = at_byte >> 2q),
//    ph5 (lo) and ph7 (hi).
//  - End of ph7:
//      inc_hori=1 for exactly one cycle.
//      Reload low bytes: pat_lo[7:0], pat_hi[7:0] <= latched lo/hi.
//      Attribute latches <= at_bits, replicated into the low 8 bits of the 8-bit attr shifters.
//  - shift_en=1 shifts each 16-bit pattern shifter and each 8-bit attribute shifter left by 1.
//    On the same edge as a reload: shift first, then load the low byte (e.g. {pat[14:7], new}).
//  - pixel is registered, 1 cycle after shifter state. Bit taken = bit (15-fine_x) of the
//    pattern shifters and bit (7-fine_x) of the attribute shifters.
//  - shift_en and fetch_en are independent; shift_en=0 holds the shifters even while fetching.
//  - rst mid-group aborts the group; the first fetch after reset starts at ph0.
// CONFIGURATION
//  `define BG_LEFT_CLIP_EN
//    Defined: pixel is forced to 0 when show_left=0 and dot_x<8 (registered with pixel).
//    Undefined: dot_x and show_left are ignored, and no clip logic is generated.
// STRUCTURE
//  - Package ppu_pkg: phase enum (PH_NT0..PH_PTH1), NT_BASE/AT_OFF constants, and a loopy-v
//    struct typedef (fine_y, nt, coarse_y, coarse_x).
//  - Sub-module bg_shifter: two 16-bit pattern shifters, two 8-bit attribute shifters and the
//    fine_x pixel mux. The bg_fetch top holds the sequencer, address generation and latches.
// TESTING
//  1. v=15'h0000, pt_sel=0, memory NT[0]=8'h24:
//     -> ph4 addr=14'h0240, ph6 addr=14'h0248, inc_hori high at ph7 only.
//  2. v=15'h0C63 (nt=3, coarse_y=3, coarse_x=3):
//     -> ph2 addr=14'h2FC0 | 0 | 0 = 14'h2FC0, q=2'b11, at_byte=8'hC0 -> at_bits=2'b11.
//  3. PT lo=8'h80, hi=8'h80, at_bits=2'b01, fine_x=0, shift_en=1 continuously:
//     -> pixel=4'h7 on the first dot after the group reaches bit 15, then 4'h4 for 7 dots.
//  4. fine_x=3, same data as test 3 -> the 4'h7 pixel appears 3 dots earlier.
//  5. fetch_en dropped at ph5:
//     -> no inc_hori, shifters unchanged; on re-enable, the first addr is the NT address.
//  6. BG_LEFT_CLIP_EN defined, show_left=0, nonzero pattern:
//     -> pixel=0 for dot_x 0..7, nonzero at dot_x=8. Undefined -> nonzero at dot_x=0.
//     Also: rst asserted at ph3 -> addr=0, pixel=0, phase=0 next cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// ppu_pkg : shared types and constants for the PPU background fetch path
// Rev 1.0 : initial release
// ============================================================================
package ppu_pkg;

    localparam logic [13:0] NT_BASE = 14'h2000;
    localparam logic [9:0]  AT_OFF  = 10'h3C0;

    typedef enum logic [2:0] {
        PH_NT0  = 3'd0,
        PH_NT1  = 3'd1,
        PH_AT0  = 3'd2,
        PH_AT1  = 3'd3,
        PH_PTL0 = 3'd4,
        PH_PTL1 = 3'd5,
        PH_PTH0 = 3'd6,
        PH_PTH1 = 3'd7
    } phase_t;

    typedef struct packed {
        logic [2:0] fine_y;
        logic [1:0] nt;
        logic [4:0] coarse_y;
        logic [4:0] coarse_x;
    } loopy_v_t;

endpackage
`default_nettype wire

// File: rtl/bg_shifter.sv
`default_nettype none
// ============================================================================
// bg_shifter : background pattern/attribute shifters and fine-X pixel mux
// Rev 1.0 : initial release
// ============================================================================
module bg_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en_i,
    input  logic       load_i,
    input  logic [7:0] pat_lo_i,
    input  logic [7:0] pat_hi_i,
    input  logic [1:0] attr_i,
    input  logic [2:0] fine_x_i,
    input  logic       clip_i,
    output logic [3:0] pixel_o
);
    logic [15:0] pl_q, pl_d, ph_q, ph_d;
    logic [7:0]  al_q, al_d, ah_q, ah_d;
    logic [1:0]  alat_q, alat_d;
    logic [3:0]  pix_q, pix_d;
    logic [3:0]  w_pidx;
    logic [2:0]  w_aidx;

    // Attribute shifters refill from the latch so they stay valid across all 16 pattern bits.
    always_comb begin
        pl_d   = pl_q;
        ph_d   = ph_q;
        al_d   = al_q;
        ah_d   = ah_q;
        alat_d = alat_q;
        if (shift_en_i) begin
            pl_d = {pl_q[14:0], 1'b0};
            ph_d = {ph_q[14:0], 1'b0};
            al_d = {al_q[6:0], alat_q[0]};
            ah_d = {ah_q[6:0], alat_q[1]};
        end
        if (load_i) begin
            pl_d[7:0] = pat_lo_i;
            ph_d[7:0] = pat_hi_i;
            al_d      = {8{attr_i[0]}};
            ah_d      = {8{attr_i[1]}};
            alat_d    = attr_i;
        end
    end

    assign w_aidx = ~fine_x_i;
    assign w_pidx = {1'b1, ~fine_x_i};

    always_comb begin
        pix_d = {ah_q[w_aidx], al_q[w_aidx], ph_q[w_pidx], pl_q[w_pidx]};
        if (clip_i) begin
            pix_d = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pl_q   <= 16'h0000;
            ph_q   <= 16'h0000;
            al_q   <= 8'h00;
            ah_q   <= 8'h00;
            alat_q <= 2'b00;
            pix_q  <= 4'h0;
        end else begin
            pl_q   <= pl_d;
            ph_q   <= ph_d;
            al_q   <= al_d;
            ah_q   <= ah_d;
            alat_q <= alat_d;
            pix_q  <= pix_d;
        end
    end

    assign pixel_o = pix_q;

endmodule
`default_nettype wire

// File: rtl/bg_fetch.sv
`default_nettype none
// ============================================================================
// bg_fetch : 2C02 background NT/AT/PT fetch sequencer feeding bg_shifter.
//            Optional left-column clip enabled by `define BG_LEFT_CLIP_EN.
// Rev 1.0 : initial release
// ============================================================================
module bg_fetch #(
    parameter int          ADDR_W  = 14,
    parameter logic [13:0] NT_BASE = ppu_pkg::NT_BASE,
    parameter logic [9:0]  AT_OFF  = ppu_pkg::AT_OFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              shift_en,
    input  logic [14:0]       v,
    input  logic [2:0]        fine_x,
    input  logic              pt_sel,
    input  logic [7:0]        dot_x,
    input  logic              show_left,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    input  logic [7:0]        data_i,
    output logic              inc_hori,
    output logic [3:0]        pixel
);
    import ppu_pkg::*;

    phase_t            phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        nt_q, lo_q, hi_q;
    logic [1:0]        quad_q, at_bits_q;

    loopy_v_t    w_lv;
    logic [13:0] w_nt_addr, w_at_addr, w_ptl_addr, w_pth_addr, w_addr14;
    logic        w_ld_nt, w_ld_quad, w_ld_at, w_ld_lo, w_ld_hi, w_reload;
    logic [1:0]  w_at_bits;
    logic        w_clip;

    assign w_lv = loopy_v_t'(v);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_NT0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Dropping fetch_en abandons the current group; the next one starts at NT.
    always_comb begin
        phase_d = PH_NT0;
        if (fetch_en) begin
            phase_d = phase_t'(phase_q + 3'd1);
        end
    end

    assign w_nt_addr  = NT_BASE | {2'b00, w_lv.nt, w_lv.coarse_y, w_lv.coarse_x};
    assign w_at_addr  = NT_BASE | {2'b00, w_lv.nt, 10'h000} | {4'h0, AT_OFF}
                      | {8'h00, w_lv.coarse_y[4:2], w_lv.coarse_x[4:2]};
    assign w_ptl_addr = {1'b0, pt_sel, nt_q, 1'b0, w_lv.fine_y};
    assign w_pth_addr = w_ptl_addr | 14'h0008;

    always_comb begin
        w_addr14  = w_pth_addr;
        w_ld_nt   = 1'b0;
        w_ld_quad = 1'b0;
        w_ld_at   = 1'b0;
        w_ld_lo   = 1'b0;
        w_ld_hi   = 1'b0;
        unique case (phase_d)
            PH_NT0, PH_NT1:   w_addr14 = w_nt_addr;
            PH_AT0, PH_AT1:   w_addr14 = w_at_addr;
            PH_PTL0, PH_PTL1: w_addr14 = w_ptl_addr;
            default:          w_addr14 = w_pth_addr;
        endcase
        addr_d = ADDR_W'(w_addr14);
        if (fetch_en) begin
            w_ld_nt   = (phase_q == PH_NT1);
            w_ld_quad = (phase_q == PH_AT0);
            w_ld_at   = (phase_q == PH_AT1);
            w_ld_lo   = (phase_q == PH_PTL1);
            w_ld_hi   = (phase_q == PH_PTH1);
        end
    end

    assign w_reload = w_ld_hi;

    always_comb begin
        unique case (quad_q)
            2'd0:    w_at_bits = data_i[1:0];
            2'd1:    w_at_bits = data_i[3:2];
            2'd2:    w_at_bits = data_i[5:4];
            default: w_at_bits = data_i[7:6];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            nt_q      <= 8'h00;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            quad_q    <= 2'b00;
            at_bits_q <= 2'b00;
        end else begin
            addr_q <= addr_d;
            if (w_ld_nt)   nt_q      <= data_i;
            if (w_ld_quad) quad_q    <= {w_lv.coarse_y[1], w_lv.coarse_x[1]};
            if (w_ld_at)   at_bits_q <= w_at_bits;
            if (w_ld_lo)   lo_q      <= data_i;
            if (w_ld_hi)   hi_q      <= data_i;
        end
    end

`ifdef BG_LEFT_CLIP_EN
    assign w_clip = !show_left && (dot_x < 8'd8);
`else
    logic unused_clip_inputs;
    assign unused_clip_inputs = ^{dot_x, show_left};
    assign w_clip             = 1'b0;
`endif

    // The PT-hi byte arrives on the reload edge itself, so it bypasses hi_q.
    bg_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .load_i     (w_reload),
        .pat_lo_i   (lo_q),
        .pat_hi_i   (data_i),
        .attr_i     (at_bits_q),
        .fine_x_i   (fine_x),
        .clip_i     (w_clip),
        .pixel_o    (pixel)
    );

    logic unused_hi_latch;
    assign unused_hi_latch = ^hi_q;

    assign addr     = addr_q;
    assign rw       = 1'b1;
    assign inc_hori = w_reload;

endmodule
`default_nettype wire

// File: tb/tb_bg_fetch.sv
`default_nettype none
// ============================================================================
// tb_bg_fetch : directed self-checking bench for bg_fetch with a 1-cycle
//               latency memory model.
// Rev 1.0 : initial release
// ============================================================================
module tb_bg_fetch;

    logic        clk = 1'b0;
    logic        rst, fetch_en, shift_en, pt_sel, show_left;
    logic [14:0] v;
    logic [2:0]  fine_x;
    logic [7:0]  dot_x;
    logic [13:0] addr;
    logic        rw, inc_hori;
    logic [7:0]  data_i = 8'h00;
    logic [3:0]  pixel;

    logic [7:0]  nt_val, at_val, lo_val, hi_val;
    int          n_assert = 0;
    int          n_fail   = 0;

    bg_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .shift_en  (shift_en),
        .v         (v),
        .fine_x    (fine_x),
        .pt_sel    (pt_sel),
        .dot_x     (dot_x),
        .show_left (show_left),
        .addr      (addr),
        .rw        (rw),
        .data_i    (data_i),
        .inc_hori  (inc_hori),
        .pixel     (pixel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [13:0] a);
        if (a[13]) return (a[9:6] == 4'hF) ? at_val : nt_val;
        return a[3] ? hi_val : lo_val;
    endfunction

    always @(posedge clk) data_i <= mem_rd(addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fetch_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_group(input logic [13:0] e_nt, input logic [13:0] e_at,
                             input logic [13:0] e_lo, input logic [13:0] e_hi);
        logic [13:0] exp_a;
        fetch_en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            case (p)
                0, 1:    exp_a = e_nt;
                2, 3:    exp_a = e_at;
                4, 5:    exp_a = e_lo;
                default: exp_a = e_hi;
            endcase
            check($sformatf("addr_ph%0d", p), 32'(addr), 32'(exp_a));
            check($sformatf("inc_hori_ph%0d", p), 32'(inc_hori), (p == 7) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; shift_en = 1'b0; pt_sel = 1'b0;
        show_left = 1'b1; v = 15'h0000; fine_x = 3'd0; dot_x = 8'd100;
        nt_val = 8'h24; at_val = 8'h00; lo_val = 8'h00; hi_val = 8'h00;
        tick(); tick();
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_rw", 32'(rw), 32'h1);
        check("rst_inc_hori", 32'(inc_hori), 32'h0);
        check("rst_pixel", 32'(pixel), 32'h0);

        // Basic group: NT byte 0x24 steers the pattern addresses
        rst = 1'b0;
        idle(1);
        run_group(14'h2000, 14'h23C0, 14'h0240, 14'h0248);
        check("rw_high", 32'(rw), 32'h1);
        check("inc_hori_next_ph0", 32'(inc_hori), 32'h0);

        // Attribute quadrant 3 of byte 0xC0, pattern lo 0xFF, no shifting
        v = 15'h0C63; nt_val = 8'h00; at_val = 8'hC0; lo_val = 8'hFF; hi_val = 8'h00;
        idle(1);
        run_group(14'h2C63, 14'h2FC0, 14'h0000, 14'h0008);
        idle(1);
        check("at_quad3_pixel", 32'(pixel), 32'hC);

        // Continuous fetch and shift: lo=hi=0x80, attribute 01, fine_x=0
        v = 15'h0000; at_val = 8'h01; lo_val = 8'h80; hi_val = 8'h80; shift_en = 1'b1;
        idle(1);
        run_group(14'h2000, 14'h23C0, 14'h0000, 14'h0008);
        run_group(14'h2000, 14'h23C0, 14'h0000, 14'h0008);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fx0_pixel_%0d", k), 32'(pixel), (k == 0) ? 32'h7 : 32'h4);
        end

        // fine_x=3 pulls the set pixel three dots earlier
        fine_x = 3'd3;
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("fx3_pixel_%0d", k), 32'(pixel), (k == 6) ? 32'h7 : 32'h4);
        end
        tick();

        // Partial group aborted at ph5: no inc_hori, no reload, restart at NT
        shift_en = 1'b0; fine_x = 3'd0; lo_val = 8'h00; hi_val = 8'h00; at_val = 8'h02;
        for (int p = 0; p < 5; p++) begin
            check($sformatf("partial_inc_ph%0d", p), 32'(inc_hori), 32'h0);
            tick();
        end
        fetch_en = 1'b0;
        check("partial_inc_ph5", 32'(inc_hori), 32'h0);
        tick();
        check("abort_addr_nt", 32'(addr), 32'h2000);
        check("abort_pixel_hold", 32'(pixel), 32'h7);
        tick();
        check("abort_pixel_hold2", 32'(pixel), 32'h7);
        run_group(14'h2000, 14'h23C0, 14'h0000, 14'h0008);
        idle(1);
        check("reload_noshift_pixel", 32'(pixel), 32'hB);

        // Left-column clip
        show_left = 1'b0;
        dot_x = 8'd0; tick();
`ifdef BG_LEFT_CLIP_EN
        check("clip_dot0", 32'(pixel), 32'h0);
`else
        check("clip_dot0", 32'(pixel), 32'hB);
`endif
        dot_x = 8'd7; tick();
`ifdef BG_LEFT_CLIP_EN
        check("clip_dot7", 32'(pixel), 32'h0);
`else
        check("clip_dot7", 32'(pixel), 32'hB);
`endif
        dot_x = 8'd8; tick();
        check("clip_dot8", 32'(pixel), 32'hB);
        show_left = 1'b1; dot_x = 8'd0; tick();
        check("show_left_dot0", 32'(pixel), 32'hB);

        // Reset at ph3 aborts the group; fetching resumes from ph0
        v = 15'h0C63;
        idle(1);
        fetch_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_pixel", 32'(pixel), 32'h0);
        check("midrst_inc_hori", 32'(inc_hori), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_ph1_addr", 32'(addr), 32'h2C63);
        tick();
        check("post_rst_ph2_addr", 32'(addr), 32'h2FC0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
